// File: rtl/wb_io_pkg.sv
// Shared definitions for the Wishbone GPIO/IRQ controller: register offsets,
// identification word and bus FSM states.
package wb_io_pkg;

  localparam logic [7:0] OFF_OUT     = 8'h00;
  localparam logic [7:0] OFF_OEB     = 8'h04;
  localparam logic [7:0] OFF_IN      = 8'h08;
  localparam logic [7:0] OFF_RISE_EN = 8'h0C;
  localparam logic [7:0] OFF_FALL_EN = 8'h10;
  localparam logic [7:0] OFF_STATUS  = 8'h14;
  localparam logic [7:0] OFF_ID      = 8'h18;

  localparam logic [31:0] ID_VALUE = 32'h4B49_4350;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/io_edge_detect.sv
// Pad input synchroniser with per-pin rising/falling edge detection, gated
// off until the pipeline holds genuine pad samples after reset.
module io_edge_detect #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_pins,
  input  logic [W-1:0] i_rise_en,
  input  logic [W-1:0] i_fall_en,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;
  logic [W-1:0] r_prev;
  logic [1:0]   r_prime_cnt;
  logic         w_primed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev      <= '0;
      r_prime_cnt <= '0;
    end else begin
      r_sync1 <= i_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_prime_cnt != 2'd3) r_prime_cnt <= r_prime_cnt + 2'd1;
    end
  end

  // sync2 and prev both carry real pad samples only after the third edge
  assign w_primed = (r_prime_cnt == 2'd3);

  assign o_sync = r_sync2;
  assign o_rise = w_primed ? (r_sync2 & ~r_prev & i_rise_en) : '0;
  assign o_fall = w_primed ? (~r_sync2 & r_prev & i_fall_en) : '0;

endmodule

// File: rtl/wb_io_ctrl.sv
// Wishbone slave owning the user GPIO pins: output/enable registers,
// synchronised input readback and edge interrupts with W1C status.
import wb_io_pkg::*;

module wb_io_ctrl #(
  parameter int          NIO       = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic [31:0]    wbs_dat_o,
  output logic           wbs_ack_o,
  input  logic [NIO-1:0] io_in,
  output logic [NIO-1:0] io_out,
  output logic [NIO-1:0] io_oeb,
  output logic [2:0]     irq
);

  bus_state_t     r_state;
  bus_state_t     w_state_nxt;

  logic [NIO-1:0] r_out;
  logic [NIO-1:0] r_oeb;
  logic [NIO-1:0] r_rise_en;
  logic [NIO-1:0] r_fall_en;
  logic [NIO-1:0] r_status;
  logic           r_irq;
  logic [31:0]    r_dat;

  logic           w_hit;
  logic           w_req;
  logic           w_wr;
  logic [31:0]    w_rdata;
  logic [NIO-1:0] w_clr;
  logic [NIO-1:0] w_sync;
  logic [NIO-1:0] w_rise;
  logic [NIO-1:0] w_fall;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  sel);
    logic [31:0] m;
    m = lane_mask(sel);
    return (old & ~m) | (data & m);
  endfunction

  io_edge_detect #(.W(NIO)) u_edge (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_ni),
    .i_pins    (io_in),
    .i_rise_en (r_rise_en),
    .i_fall_en (r_fall_en),
    .o_sync    (w_sync),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  assign w_hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_req = (r_state == IDLE) && wbs_cyc_i && wbs_stb_i && w_hit;
  assign w_wr  = w_req && wbs_we_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Unaligned byte addresses never match a case item and so read as zero
  always_comb begin
    w_rdata = '0;
    case (wbs_adr_i[7:0])
      OFF_OUT:     w_rdata[NIO-1:0] = r_out;
      OFF_OEB:     w_rdata[NIO-1:0] = r_oeb;
      OFF_IN:      w_rdata[NIO-1:0] = w_sync;
      OFF_RISE_EN: w_rdata[NIO-1:0] = r_rise_en;
      OFF_FALL_EN: w_rdata[NIO-1:0] = r_fall_en;
      OFF_STATUS:  w_rdata[NIO-1:0] = r_status;
      OFF_ID:      w_rdata = ID_VALUE;
      default:     w_rdata = '0;
    endcase
  end

  assign w_clr = (w_wr && (wbs_adr_i[7:0] == OFF_STATUS))
               ? NIO'(wbs_dat_i & lane_mask(wbs_sel_i)) : '0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_out     <= '0;
      r_oeb     <= '1;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      case (wbs_adr_i[7:0])
        OFF_OUT:     r_out     <= NIO'(lane_merge(32'(r_out), wbs_dat_i, wbs_sel_i));
        OFF_OEB:     r_oeb     <= NIO'(lane_merge(32'(r_oeb), wbs_dat_i, wbs_sel_i));
        OFF_RISE_EN: r_rise_en <= NIO'(lane_merge(32'(r_rise_en), wbs_dat_i, wbs_sel_i));
        OFF_FALL_EN: r_fall_en <= NIO'(lane_merge(32'(r_fall_en), wbs_dat_i, wbs_sel_i));
        default:     ;
      endcase
    end
  end

  // A fresh edge re-sets its bit even when cleared in the same cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_rise | w_fall;
      r_irq    <= |r_status;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                r_dat <= '0;
    else if (w_req && !wbs_we_i)   r_dat <= w_rdata;
    else                           r_dat <= '0;
  end

  assign wbs_dat_o = r_dat;
  assign wbs_ack_o = (r_state == ACK);
  assign io_out    = r_out;
  assign io_oeb    = r_oeb;
  assign irq       = {2'b00, r_irq};

endmodule

// File: tb/tb_wb_io_ctrl.sv
// Directed self-checking bench for wb_io_ctrl.
module tb_wb_io_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic [15:0] io_in, io_out, io_oeb;
  logic [2:0]  irq;

  int total = 0;
  int fails = 0;

  wb_io_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
  endtask

  // Called #1 after a clock edge; returns #1 after the ACK->IDLE edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b1, a, d, s);
    @(posedge clk); #1;
    chk("wr_ack", 32'(ack), 32'd1);
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    drive(1'b0, a, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("rd_ack", 32'(ack), 32'd1);
    d = dat_o;
    idle_bus();
    @(posedge clk); #1;
    chk("rd_dat_idle", dat_o, 32'h0);
  endtask

  logic [31:0] rd;
  int          acks;

  initial begin
    rst_n = 1'b0;
    io_in = 16'hFFFF;
    idle_bus();

    // Reset values, then release with all pads high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
    chk("rst_out", 32'(io_out), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (irq !== 3'b000) acks++;
    end
    chk("post_rst_irq", 32'(acks), 32'd0);
    bus_read(32'h3000_0014, rd);
    chk("post_rst_status", rd, 32'h0);

    // Byte-lane write to OUT, visible together with a single-cycle ack
    chk("ack_before_stb", 32'(ack), 32'd0);
    drive(1'b1, 32'h3000_0000, 32'h0000_A55A, 4'b0001);
    #4;
    chk("ack_not_early", 32'(ack), 32'd0);
    @(posedge clk); #1;
    chk("out_wr_ack", 32'(ack), 32'd1);
    chk("out_visible", 32'(io_out), 32'h0000_005A);
    idle_bus();
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack), 32'd0);
    bus_read(32'h3000_0000, rd);
    chk("out_readback", rd, 32'h0000_005A);
    bus_write(32'h3000_0000, 32'hFFFF_1234, 4'b0010);
    chk("out_lane1", 32'(io_out), 32'h0000_125A);

    // Rising edge on pin 0 and W1C
    io_in = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    bus_write(32'h3000_000C, 32'h0000_0001, 4'hF);
    io_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 32'd1);
    bus_read(32'h3000_0014, rd);
    chk("status_rise", rd, 32'h1);
    bus_write(32'h3000_0014, 32'h0000_0001, 4'hF);
    chk("irq_cleared", 32'(irq), 32'd0);
    bus_read(32'h3000_0014, rd);
    chk("status_cleared", rd, 32'h0);

    // Set beats W1C on pin 3
    bus_write(32'h3000_000C, 32'h0000_0009, 4'hF);
    bus_write(32'h3000_0010, 32'h0000_0008, 4'hF);
    io_in[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus_read(32'h3000_0014, rd);
    chk("status_pin3_rise", rd, 32'h8);
    io_in[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 32'h3000_0014, 32'h0000_0008, 4'hF);
    @(posedge clk); #1;
    chk("w1c_race_ack", 32'(ack), 32'd1);
    idle_bus();
    @(posedge clk); #1;
    bus_read(32'h3000_0014, rd);
    chk("set_wins", rd, 32'h8);
    bus_write(32'h3000_0014, 32'h0000_0008, 4'hF);
    bus_read(32'h3000_0014, rd);
    chk("w1c_plain", rd, 32'h0);

    // Decode
    bus_read(32'h3000_0018, rd);
    chk("id", rd, 32'h4B49_4350);
    bus_read(32'h3000_0040, rd);
    chk("unmapped", rd, 32'h0);
    bus_read(32'h3000_0001, rd);
    chk("unaligned", rd, 32'h0);
    bus_read(32'h3000_0008, rd);
    chk("in_read", rd, 32'h0000_0001);
    bus_write(32'h3000_0008, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h3000_0008, rd);
    chk("in_ro", rd, 32'h0000_0001);
    drive(1'b0, 32'h3000_0100, 32'h0, 4'hF);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("miss_no_ack", 32'(acks), 32'd0);
    idle_bus();
    @(posedge clk); #1;

    // Reset during the ACK cycle of an OEB write
    drive(1'b1, 32'h3000_0004, 32'h0000_0000, 4'hF);
    @(posedge clk); #1;
    chk("oeb_wr_ack", 32'(ack), 32'd1);
    chk("oeb_written", 32'(io_oeb), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
    chk("mid_rst_out", 32'(io_out), 32'h0);
    idle_bus();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_mid_ack", 32'(ack), 32'd0);
    bus_read(32'h3000_0004, rd);
    chk("post_mid_oeb", rd, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
